led_pattern_seq: RTL and testbench

- Parametrised LED pattern sequencer. Generalises the fixed 16-bit walking light to any width, with a programmable step rate and four run-time-selectable patterns.
- Drives the board LED bank directly from the top level.
- Internal prescaler derives the step rate from the system clock; `step` and `wrap` strobes are provided for other logic.

---
 rtl/led_pattern_seq.sv | 127 ++++++++++++
 tb/tb_led_pattern_seq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_seq.sv
// led_pattern_seq: parametrised walk/bounce/fill LED sequencer with prescaler.
// Define LED_SEQ_PAUSE_EN to add a pause input with a blinking pause display.
module led_pattern_seq #(
    parameter int WIDTH    = 16,
    parameter int TICK_DIV = 50000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
`ifdef LED_SEQ_PAUSE_EN
    input  logic             pause,
`endif
    output logic [WIDTH-1:0] led,
    output logic             step,
    output logic             wrap
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int PW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [PW-1:0] POS_LAST = PW'(WIDTH - 1);
    localparam logic [PW-1:0] POS_FULL = PW'(WIDTH);
    localparam logic [PW-1:0] POS_ONE  = PW'(1);

    typedef enum logic [1:0] {WALK_L, WALK_R, BOUNCE, FILL} mode_e;
    typedef enum logic {UP, DOWN} dir_e;

    mode_e            mode_q;
    dir_e             dir_q, dir_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    pos_q, pos_d;
    logic [WIDTH-1:0] led_q, led_d;
    logic [WIDTH-1:0] pat;
    logic [WIDTH:0]   one_w, fill_w;
    logic             tick_q, step_q, wrap_q;
    logic             mode_chg, tick;
    logic             paused, resume, blink;

`ifdef LED_SEQ_PAUSE_EN
    localparam logic [CW-1:0] CNT_HALF = CW'(TICK_DIV / 2);
    logic pause_q;

    assign paused = en && pause;
    assign resume = !pause && pause_q;
    assign blink  = paused && (cnt_q < CNT_HALF);

    always_ff @(posedge clk) begin
        if (reset) pause_q <= 1'b0;
        else       pause_q <= pause;
    end
`else
    assign paused = 1'b0;
    assign resume = 1'b0;
    assign blink  = 1'b0;
`endif

    always_comb begin
        mode_chg = (mode_e'(mode) != mode_q);
        tick = en && !paused && !resume && !mode_chg && (cnt_q == CNT_MAX);
        cnt_d = cnt_q;
        pos_d = pos_q;
        dir_d = dir_q;
        if (mode_chg || resume) cnt_d = '0;
        else if (paused)        cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_ONE;
        else if (tick)          cnt_d = '0;
        else if (en)            cnt_d = cnt_q + CNT_ONE;
        if (mode_chg) begin
            pos_d = '0;
            dir_d = UP;
        end else if (tick) begin
            unique case (mode_q)
                WALK_L, WALK_R: pos_d = (pos_q == POS_LAST) ? '0 : pos_q + POS_ONE;
                BOUNCE: begin
                    // Endpoints turn around immediately so each is shown once
                    if (dir_q == UP && pos_q != POS_LAST) begin
                        pos_d = pos_q + POS_ONE;
                    end else begin
                        pos_d = pos_q - POS_ONE;
                        dir_d = DOWN;
                    end
                    if (pos_d == '0) dir_d = UP;
                end
                FILL: pos_d = (pos_q == POS_FULL) ? '0 : pos_q + POS_ONE;
            endcase
        end
    end

    always_comb begin
        one_w  = {{WIDTH{1'b0}}, 1'b1};
        fill_w = (one_w << pos_q) - one_w;
        pat    = '0;
        unique case (mode_q)
            WALK_L, BOUNCE: pat = WIDTH'(1) << pos_q;
            WALK_R:         pat = WIDTH'(1) << (POS_LAST - pos_q);
            FILL:           pat = WIDTH'(fill_w);
        endcase
        led_d = blink ? '1 : pat;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            pos_q  <= '0;
            dir_q  <= UP;
            mode_q <= mode_e'(mode);
            tick_q <= 1'b0;
            led_q  <= '0;
            step_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pos_q  <= pos_d;
            dir_q  <= dir_d;
            mode_q <= mode_e'(mode);
            tick_q <= tick;
            led_q  <= led_d;
            step_q <= tick_q;
            wrap_q <= tick_q && (pos_q == '0);
        end
    end

    assign led  = led_q;
    assign step = step_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// tb_led_pattern_seq: directed stimulus against a step-index model of the sequencer.
// Two instances run in lockstep: TICK_DIV=3 and TICK_DIV=1.
module tb_led_pattern_seq;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset, en;
    logic [1:0]   mode;
    logic [W-1:0] led0, led1;
    logic         step0, step1, wrap0, wrap1;
    int           n_chk = 0;
    int           n_err = 0;

    always #5 clk = ~clk;

    led_pattern_seq #(.WIDTH(W), .TICK_DIV(3)) dut0 (
        .clk(clk), .reset(reset), .en(en), .mode(mode),
`ifdef LED_SEQ_PAUSE_EN
        .pause(1'b0),
`endif
        .led(led0), .step(step0), .wrap(wrap0)
    );

    led_pattern_seq #(.WIDTH(W), .TICK_DIV(1)) dut1 (
        .clk(clk), .reset(reset), .en(en), .mode(mode),
`ifdef LED_SEQ_PAUSE_EN
        .pause(1'b0),
`endif
        .led(led1), .step(step1), .wrap(wrap1)
    );

    // Model: step index k within the mode's period, pattern looked up from k
    int           m_cnt  [2];
    int           m_k    [2];
    logic [1:0]   m_mode [2];
    logic [W-1:0] m_led  [2];
    logic         m_step [2];
    logic         m_wrap [2];
    logic         m_pend [2];
    logic         m_valid = 1'b0;

    function automatic int tdiv(input int i);
        return (i == 0) ? 3 : 1;
    endfunction

    function automatic int period(input logic [1:0] md);
        case (md)
            2'd2:    return 2 * W - 2;
            2'd3:    return W + 1;
            default: return W;
        endcase
    endfunction

    function automatic logic [W-1:0] pat(input logic [1:0] md, input int k);
        int v;
        case (md)
            2'd0:    v = 1 << k;
            2'd1:    v = 1 << (W - 1 - k);
            2'd2:    v = (k < W) ? (1 << k) : (1 << (2 * W - 2 - k));
            default: v = (1 << k) - 1;
        endcase
        return v[W-1:0];
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_cnt[i]  <= 0;
                m_k[i]    <= 0;
                m_mode[i] <= mode;
                m_led[i]  <= '0;
                m_step[i] <= 1'b0;
                m_wrap[i] <= 1'b0;
                m_pend[i] <= 1'b0;
            end else begin
                m_led[i]  <= pat(m_mode[i], m_k[i]);
                m_step[i] <= m_pend[i];
                m_wrap[i] <= m_pend[i] && (m_k[i] == 0);
                m_mode[i] <= mode;
                if (mode != m_mode[i]) begin
                    m_k[i]    <= 0;
                    m_cnt[i]  <= 0;
                    m_pend[i] <= 1'b0;
                end else if (en && m_cnt[i] == tdiv(i) - 1) begin
                    m_cnt[i]  <= 0;
                    m_k[i]    <= (m_k[i] + 1) % period(m_mode[i]);
                    m_pend[i] <= 1'b1;
                end else begin
                    if (en) m_cnt[i] <= m_cnt[i] + 1;
                    m_pend[i] <= 1'b0;
                end
            end
        end
        if (reset) m_valid <= 1'b1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        if (m_valid) begin
            chk("led0", 32'(led0), 32'(m_led[0]));
            chk("step0", 32'(step0), 32'(m_step[0]));
            chk("wrap0", 32'(wrap0), 32'(m_wrap[0]));
            chk("led1", 32'(led1), 32'(m_led[1]));
            chk("step1", 32'(step1), 32'(m_step[1]));
            chk("wrap1", 32'(wrap1), 32'(m_wrap[1]));
        end
    endtask

    task automatic wait_step(input logic [W-1:0] exp_led, input logic exp_wrap, input int gap);
        int c = 0;
        do begin
            cyc();
            c++;
        end while (!step0 && c < 20);
        chk("step_gap", 32'(c), 32'(gap));
        chk("step_led", 32'(led0), 32'(exp_led));
        chk("step_wrap", 32'(wrap0), 32'(exp_wrap));
    endtask

    task automatic new_mode(input logic [1:0] md, input logic [W-1:0] start);
        mode = md;
        cyc();
        cyc();
        chk("mode_start", 32'(led0), 32'(start));
        chk("mode_nostep", 32'(step0), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b1;
        mode  = 2'd0;
        repeat (3) cyc();
        chk("rst_led", 32'(led0), 32'd0);
        chk("rst_step", 32'(step0), 32'd0);
        chk("rst_wrap", 32'(wrap0), 32'd0);
        chk("rst_led1", 32'(led1), 32'd0);

        reset = 1'b0;
        cyc();
        chk("start_led", 32'(led0), 32'h1);
        chk("start_step", 32'(step0), 32'd0);
        wait_step(4'b0010, 1'b0, 3);
        wait_step(4'b0100, 1'b0, 3);
        wait_step(4'b1000, 1'b0, 3);
        wait_step(4'b0001, 1'b1, 3);

        new_mode(2'd2, 4'b0001);
        wait_step(4'b0010, 1'b0, 3);
        wait_step(4'b0100, 1'b0, 3);
        wait_step(4'b1000, 1'b0, 3);
        wait_step(4'b0100, 1'b0, 3);
        wait_step(4'b0010, 1'b0, 3);
        wait_step(4'b0001, 1'b1, 3);

        new_mode(2'd3, 4'b0000);
        wait_step(4'b0001, 1'b0, 3);
        wait_step(4'b0011, 1'b0, 3);
        wait_step(4'b0111, 1'b0, 3);
        wait_step(4'b1111, 1'b0, 3);
        wait_step(4'b0000, 1'b1, 3);

        // Change mode in the very cycle the prescaler would tick
        new_mode(2'd1, 4'b1000);
        wait_step(4'b0100, 1'b0, 3);
        wait_step(4'b0010, 1'b0, 3);
        cyc();
        mode = 2'd0;
        cyc();
        chk("chg_led_old", 32'(led0), 32'h2);
        chk("chg_step_a", 32'(step0), 32'd0);
        cyc();
        chk("chg_led_new", 32'(led0), 32'h1);
        chk("chg_step_b", 32'(step0), 32'd0);
        wait_step(4'b0010, 1'b0, 3);

        en = 1'b0;
        repeat (5) begin
            cyc();
            chk("hold_led", 32'(led0), 32'h2);
            chk("hold_step", 32'(step0), 32'd0);
        end
        en = 1'b1;
        cyc();
        chk("resume0_a", 32'(step0), 32'd0);
        chk("resume1_a", 32'(step1), 32'd0);
        cyc();
        chk("resume1_b", 32'(step1), 32'd1);
        cyc();
        chk("resume0_c", 32'(step0), 32'd1);
        chk("resume0_led", 32'(led0), 32'h4);
        chk("resume1_c", 32'(step1), 32'd1);

        new_mode(2'd2, 4'b0001);
        wait_step(4'b0010, 1'b0, 3);
        wait_step(4'b0100, 1'b0, 3);
        reset = 1'b1;
        cyc();
        chk("midrst_led", 32'(led0), 32'd0);
        chk("midrst_step", 32'(step0), 32'd0);
        chk("midrst_wrap", 32'(wrap0), 32'd0);
        reset = 1'b0;
        cyc();
        chk("restart_led", 32'(led0), 32'h1);
        wait_step(4'b0010, 1'b0, 3);
        wait_step(4'b0100, 1'b0, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
